fifo_read: RTL



---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_read_if.sv | 40 ++++
 rtl/pkt_check.sv | 34 +++
 rtl/fifo_read.sv | 107 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the test FIFO packet writer/reader pair.
// State codes, header defaults, length limit and payload pattern.
package fifo_pkg;

  localparam int CW = 12;

  localparam logic [7:0] HEAD0_D = 8'h55;
  localparam logic [7:0] HEAD1_D = 8'hAA;
  localparam int MAX_LEN_D = 128;
  localparam int TIMEOUT_D = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_READ = 3'd2,
    ST_LAST = 3'd3
  } fifo_st_t;

  // Byte expected at packet index idx; index 2 is the free part byte.
  function automatic logic [7:0] exp_byte(
    input logic [CW-1:0] idx,
    input logic [7:0]    h0,
    input logic [7:0]    h1
  );
    logic [7:0] b;
    unique case (1'b1)
      (idx == 12'd0): b = h0;
      (idx == 12'd1): b = h1;
      default:        b = {1'b0, idx[6:0]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fifo_read_if.sv
// Bus bundle between the packet reader, its FIFO and controller.
// slave: reader side; master: FIFO/controller side.
interface fifo_read_if;
  import fifo_pkg::*;

  logic          fifo_empty;
  logic [7:0]    fifo_rxd;
  logic          fifo_rxen;
  logic          fs;
  logic          fd;
  logic [CW-1:0] data_len;
  logic [7:0]    part;
  logic          err;
  logic [CW-1:0] err_cnt;

  modport slave (
    input  fifo_empty,
    input  fifo_rxd,
    input  fs,
    input  data_len,
    output fifo_rxen,
    output fd,
    output part,
    output err,
    output err_cnt
  );

  modport master (
    output fifo_empty,
    output fifo_rxd,
    output fs,
    output data_len,
    input  fifo_rxen,
    input  fd,
    input  part,
    input  err,
    input  err_cnt
  );

endinterface

// File: rtl/pkt_check.sv
// Per-byte comparator: flags a mismatch against the pattern and
// holds the captured part byte. Ports: rd_vld, chk_num, rxd -> mis, part.
module pkt_check
  import fifo_pkg::*;
#(
  parameter logic [7:0] HEAD0 = HEAD0_D,
  parameter logic [7:0] HEAD1 = HEAD1_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_vld,
  input  logic [CW-1:0] chk_num,
  input  logic [7:0]    rxd,
  output logic          mis,
  output logic [7:0]    part
);

  logic is_part;
  logic part_ld;

  assign is_part = (chk_num == 12'd2);
  assign part_ld = rd_vld && is_part;
  assign mis = rd_vld && !is_part &&
               (rxd != exp_byte(chk_num, HEAD0, HEAD1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      part <= 8'h00;
    end else if (part_ld) begin
      part <= rxd;
    end
  end

endmodule

// File: rtl/fifo_read.sv
// Packet reader: drains data_len bytes from a standard FIFO, checks
// header/payload, reports part/err/err_cnt with fs/fd handshake.
module fifo_read
  import fifo_pkg::*;
#(
  parameter logic [7:0] HEAD0   = HEAD0_D,
  parameter logic [7:0] HEAD1   = HEAD1_D,
  parameter int         MAX_LEN = MAX_LEN_D,
  parameter int         TIMEOUT = TIMEOUT_D
) (
  input logic        clk,
  input logic        rst,
  fifo_read_if.slave bus
);

  fifo_st_t      st;
  fifo_st_t      st_nx;
  logic [CW-1:0] len_q;
  logic [CW-1:0] req_num;
  logic [CW-1:0] chk_num;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] err_cnt_q;
  logic          err_q;
  logic          rd_vld;
  logic          rxen;
  logic          mis;
  logic          len_bad;
  logic          chk_last;
  logic          stall;
  logic          tmo_hit;
  logic [7:0]    part_q;

  assign len_bad  = (len_q < 12'd3) || (len_q > 12'(MAX_LEN));
  assign rxen     = (st == ST_READ) && !bus.fifo_empty &&
                    (req_num < len_q);
  assign chk_last = rd_vld && (chk_num == len_q - 12'd1);
  // Empty while reads are still owed: the only case that can time out.
  assign stall    = (st == ST_READ) && bus.fifo_empty &&
                    (req_num < len_q);
  assign tmo_hit  = stall && (tmo_cnt == 12'(TIMEOUT - 1));

  assign bus.fifo_rxen = rxen;
  assign bus.fd        = (st == ST_LAST);
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.part      = part_q;

  pkt_check #(
    .HEAD0 (HEAD0),
    .HEAD1 (HEAD1)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .rd_vld  (rd_vld),
    .chk_num (chk_num),
    .rxd     (bus.fifo_rxd),
    .mis     (mis),
    .part    (part_q)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE: if (bus.fs) st_nx = ST_PREP;
      ST_PREP: begin
        if (len_bad) st_nx = ST_LAST;
        else if (!bus.fifo_empty) st_nx = ST_READ;
      end
      ST_READ: if (chk_last || tmo_hit) st_nx = ST_LAST;
      ST_LAST: if (!bus.fs) st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= ST_IDLE;
      len_q     <= '0;
      req_num   <= '0;
      chk_num   <= '0;
      tmo_cnt   <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      st      <= st_nx;
      rd_vld  <= rxen;
      tmo_cnt <= stall ? tmo_cnt + 12'd1 : '0;
      if (st == ST_IDLE && bus.fs) begin
        len_q     <= bus.data_len;
        req_num   <= '0;
        chk_num   <= '0;
        err_cnt_q <= '0;
        err_q     <= 1'b0;
      end
      if (st == ST_PREP && len_bad) err_q <= 1'b1;
      if (rxen) req_num <= req_num + 12'd1;
      if (rd_vld) chk_num <= chk_num + 12'd1;
      if (mis) begin
        err_q <= 1'b1;
        if (err_cnt_q != 12'hFFF) err_cnt_q <= err_cnt_q + 12'd1;
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

endmodule
